// File: rtl/isp_pkg.sv
// Shared ISP definitions: gain format constants and the AWB controller state encoding.
package isp_pkg;

    localparam int GAIN_W = 10;
    localparam logic [GAIN_W-1:0] GAIN_ONE = 10'd256;
    localparam logic [GAIN_W-1:0] GAIN_MAX = 10'd1023;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIV_R  = 2'd1,
        DIV_B  = 2'd2,
        UPDATE = 2'd3
    } awb_state_t;

endpackage

// File: rtl/awb_divider.sv
// Serial restoring divider, one quotient bit per cycle; the start cycle already performs the first step.
module awb_divider #(
    parameter int DIVIDEND_W = 36,
    parameter int DIVISOR_W  = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    logic [DIVISOR_W-1:0]  rem;
    logic [DIVISOR_W-1:0]  dsr;
    logic [DIVIDEND_W-1:0] work;
    logic [CNT_W-1:0]      count;

    logic [DIVISOR_W-1:0]  rem_in;
    logic [DIVISOR_W-1:0]  dsr_in;
    logic [DIVIDEND_W-1:0] work_in;
    logic [DIVISOR_W:0]    rem_sh;
    logic [DIVISOR_W-1:0]  rem_nx;
    logic [DIVIDEND_W-1:0] work_nx;
    logic                  qbit;

    // work holds the not-yet-consumed dividend bits and collects quotient bits from the bottom
    always_comb begin
        rem_in  = start ? '0 : rem;
        dsr_in  = start ? divisor : dsr;
        work_in = start ? dividend : work;
        rem_sh  = {rem_in, work_in[DIVIDEND_W-1]};
        qbit    = 1'b0;
        rem_nx  = rem_sh[DIVISOR_W-1:0];
        if (rem_sh >= {1'b0, dsr_in}) begin
            qbit   = 1'b1;
            rem_nx = DIVISOR_W'(rem_sh - {1'b0, dsr_in});
        end
        work_nx = {work_in[DIVIDEND_W-2:0], qbit};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy  <= 1'b1;
                count <= CNT_W'(1);
            end else if (busy) begin
                if (count == CNT_W'(DIVIDEND_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start || busy) begin
            rem  <= rem_nx;
            work <= work_nx;
            dsr  <= dsr_in;
        end
    end

    assign quotient = work;

endmodule

// File: rtl/awb_gray_world.sv
// Gray-world auto white balance: per-frame RGB statistics, R/B gain computation in blanking,
// and a 2-cycle gain/round/saturate datapath applying the previous frame's gains.
module awb_gray_world
    import isp_pkg::*;
#(
    parameter int SOURCE_H = 1024,
    parameter int SOURCE_V = 1024,
    parameter int SUM_W    = 28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_vsync,
    input  logic              in_hsync,
    input  logic              in_den,
    input  logic [7:0]        in_data_R,
    input  logic [7:0]        in_data_G,
    input  logic [7:0]        in_data_B,
    input  logic              awb_enable,
    output logic              out_vsync,
    output logic              out_hsync,
    output logic              out_den,
    output logic [7:0]        out_data_R,
    output logic [7:0]        out_data_G,
    output logic [7:0]        out_data_B,
    output logic [GAIN_W-1:0] gain_R,
    output logic [GAIN_W-1:0] gain_B,
    output logic              stat_valid
);

    localparam int DIV_W  = SUM_W + 8;
    localparam int PROD_W = 8 + GAIN_W;

    if (SUM_W < 8 + $clog2(SOURCE_H * SOURCE_V)) begin : g_sum_w_check
        $error("SUM_W too small for the configured frame size");
    end

    function automatic logic [7:0] round_sat(input logic [PROD_W-1:0] p);
        logic [PROD_W:0] s;
        s = {1'b0, p} + (PROD_W + 1)'(128);
        if (s[PROD_W:8] > (PROD_W - 7)'(255)) return 8'hFF;
        return s[15:8];
    endfunction

    function automatic logic [GAIN_W-1:0] gain_sat(input logic [DIV_W-1:0] q, input logic div_zero);
        if (div_zero) return GAIN_ONE;
        if (q > DIV_W'(GAIN_MAX)) return GAIN_MAX;
        return q[GAIN_W-1:0];
    endfunction

    awb_state_t state, state_next;

    logic              vsync_d;
    logic              frame_start, frame_end;
    logic [SUM_W-1:0]  acc_r, acc_g, acc_b;
    logic [SUM_W-1:0]  snap_r, snap_g, snap_b;
    logic [GAIN_W-1:0] pending_r, pending_b;
    logic [GAIN_W-1:0] active_r, active_b;
    logic [GAIN_W-1:0] calc_r;

    logic              div_start, div_busy, div_done;
    logic [DIV_W-1:0]  div_dividend, div_quotient;
    logic [SUM_W-1:0]  div_divisor;
    logic              snap_load, r_done, b_done;

    assign frame_start = in_vsync & ~vsync_d;
    assign frame_end   = ~in_vsync & vsync_d;

    always_ff @(posedge clk) begin
        if (reset) state <= ACCUM;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (frame_end && !div_busy) state_next = DIV_R;
            DIV_R:   if (div_done) state_next = DIV_B;
            DIV_B:   if (div_done) state_next = UPDATE;
            UPDATE:  state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // R division starts straight from the live sums; B reuses the snapshot once R finishes
    always_comb begin
        div_start    = 1'b0;
        div_dividend = {acc_g, 8'd0};
        div_divisor  = acc_r;
        snap_load    = 1'b0;
        r_done       = 1'b0;
        b_done       = 1'b0;
        case (state)
            ACCUM: begin
                if (frame_end && !div_busy) begin
                    div_start = 1'b1;
                    snap_load = 1'b1;
                end
            end
            DIV_R: begin
                div_dividend = {snap_g, 8'd0};
                div_divisor  = snap_b;
                if (div_done) begin
                    div_start = 1'b1;
                    r_done    = 1'b1;
                end
            end
            DIV_B:   b_done = div_done;
            default: ;
        endcase
    end

    awb_divider #(
        .DIVIDEND_W(DIV_W),
        .DIVISOR_W (SUM_W)
    ) u_divider (
        .clk     (clk),
        .reset   (reset),
        .start   (div_start),
        .dividend(div_dividend),
        .divisor (div_divisor),
        .busy    (div_busy),
        .done    (div_done),
        .quotient(div_quotient)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_d    <= 1'b0;
            acc_r      <= '0;
            acc_g      <= '0;
            acc_b      <= '0;
            pending_r  <= GAIN_ONE;
            pending_b  <= GAIN_ONE;
            active_r   <= GAIN_ONE;
            active_b   <= GAIN_ONE;
            stat_valid <= 1'b0;
        end else begin
            vsync_d <= in_vsync;
            if (frame_end) begin
                acc_r <= '0;
                acc_g <= '0;
                acc_b <= '0;
            end else if (in_vsync && in_den) begin
                acc_r <= acc_r + SUM_W'(in_data_R);
                acc_g <= acc_g + SUM_W'(in_data_G);
                acc_b <= acc_b + SUM_W'(in_data_B);
            end
            if (b_done) begin
                pending_r <= calc_r;
                pending_b <= gain_sat(div_quotient, snap_b == '0);
            end
            stat_valid <= b_done;
            // Gains only switch at a frame boundary so a frame is never corrected with mixed gains
            if (frame_start) begin
                active_r <= pending_r;
                active_b <= pending_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (snap_load) begin
            snap_r <= acc_r;
            snap_g <= acc_g;
            snap_b <= acc_b;
        end
        if (r_done) calc_r <= gain_sat(div_quotient, snap_r == '0);
    end

    assign gain_R = active_r;
    assign gain_B = active_b;

    logic [GAIN_W-1:0] gain_r_eff, gain_b_eff;
    logic [PROD_W-1:0] prod_r_p1, prod_g_p1, prod_b_p1;
    logic              vld_p1, vsync_p1, hsync_p1;

    assign gain_r_eff = awb_enable ? active_r : GAIN_ONE;
    assign gain_b_eff = awb_enable ? active_b : GAIN_ONE;

    // Stage 1: pixel x gain
    always_ff @(posedge clk) begin
        prod_r_p1 <= PROD_W'(in_data_R) * PROD_W'(gain_r_eff);
        prod_g_p1 <= PROD_W'(in_data_G) * PROD_W'(GAIN_ONE);
        prod_b_p1 <= PROD_W'(in_data_B) * PROD_W'(gain_b_eff);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            vsync_p1 <= 1'b0;
            hsync_p1 <= 1'b0;
        end else begin
            vld_p1   <= in_den;
            vsync_p1 <= in_vsync;
            hsync_p1 <= in_hsync;
        end
    end

    // Stage 2: round, saturate, blank outside den
    always_ff @(posedge clk) begin
        if (reset) begin
            out_vsync  <= 1'b0;
            out_hsync  <= 1'b0;
            out_den    <= 1'b0;
            out_data_R <= 8'd0;
            out_data_G <= 8'd0;
            out_data_B <= 8'd0;
        end else begin
            out_vsync  <= vsync_p1;
            out_hsync  <= hsync_p1;
            out_den    <= vld_p1;
            out_data_R <= vld_p1 ? round_sat(prod_r_p1) : 8'd0;
            out_data_G <= vld_p1 ? round_sat(prod_g_p1) : 8'd0;
            out_data_B <= vld_p1 ? round_sat(prod_b_p1) : 8'd0;
        end
    end

endmodule

// File: tb/tb_awb_gray_world.sv
// Directed bench for awb_gray_world: every driven cycle pushes its expected output into a
// scoreboard queue that is popped two cycles later; gains and stat timing checked against constants.
module tb_awb_gray_world;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_vsync, in_hsync, in_den;
    logic [7:0] in_data_R, in_data_G, in_data_B;
    logic       awb_enable;
    logic       out_vsync, out_hsync, out_den;
    logic [7:0] out_data_R, out_data_G, out_data_B;
    logic [9:0] gain_R, gain_B;
    logic       stat_valid;

    always #5 clk = ~clk;

    awb_gray_world dut (
        .clk       (clk),
        .reset     (reset),
        .in_vsync  (in_vsync),
        .in_hsync  (in_hsync),
        .in_den    (in_den),
        .in_data_R (in_data_R),
        .in_data_G (in_data_G),
        .in_data_B (in_data_B),
        .awb_enable(awb_enable),
        .out_vsync (out_vsync),
        .out_hsync (out_hsync),
        .out_den   (out_den),
        .out_data_R(out_data_R),
        .out_data_G(out_data_G),
        .out_data_B(out_data_B),
        .gain_R    (gain_R),
        .gain_B    (gain_B),
        .stat_valid(stat_valid)
    );

    int total = 0;
    int bad   = 0;
    logic [26:0] q[$];
    int exp_gr = 256;
    int exp_gb = 256;
    bit en     = 1'b1;
    bit rst_v  = 1'b1;
    bit sv_seen;

    function automatic logic [7:0] app(input int p, input int g);
        int v;
        v = (p * g + 128) / 256;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit vs, input bit hs, input bit de, input int r, input int g, input int b);
        logic [26:0] e;
        int ger, geb;
        @(posedge clk);
        #1;
        sv_seen = stat_valid;
        if (q.size() >= 2) begin
            e = q.pop_front();
            chk("pix", 32'({out_vsync, out_hsync, out_den, out_data_R, out_data_G, out_data_B}), 32'(e));
        end
        reset      = rst_v;
        awb_enable = en;
        in_vsync   = vs;
        in_hsync   = hs;
        in_den     = de;
        in_data_R  = 8'(r);
        in_data_G  = 8'(g);
        in_data_B  = 8'(b);
        ger = en ? exp_gr : 256;
        geb = en ? exp_gb : 256;
        e = {vs, hs, de, (de ? app(r, ger) : 8'd0), (de ? 8'(g) : 8'd0), (de ? app(b, geb) : 8'd0)};
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    // One frame: even/odd pixel R values, given expected active gains for this frame
    task automatic frame(input int r0, input int r1, input int g, input int b, input int lines,
                         input int ppl, input bit den_on, input int ger, input int geb);
        exp_gr = ger;
        exp_gb = geb;
        tick(1'b1, 1'b0, 1'b0, 0, 0, 0);
        tick(1'b1, 1'b0, 1'b0, 0, 0, 0);
        chk("gain_R_active", 32'(gain_R), 32'(ger));
        chk("gain_B_active", 32'(gain_B), 32'(geb));
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < ppl; p++) tick(1'b1, 1'b1, den_on, (p % 2 == 1) ? r1 : r0, g, b);
            tick(1'b1, 1'b0, 1'b0, 0, 0, 0);
            tick(1'b1, 1'b0, 1'b0, 0, 0, 0);
        end
        tick(1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic wait_stat(input bit check_lat);
        int cnt;
        bit got;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 200) begin
            tick(1'b0, 1'b0, 1'b0, 0, 0, 0);
            cnt++;
            if (sv_seen) got = 1'b1;
        end
        chk("stat_seen", 32'(got), 32'd1);
        if (check_lat) chk("stat_latency", 32'(cnt), 32'd73);
        tick(1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("stat_pulse_width", 32'(sv_seen), 32'd0);
    endtask

    task automatic check_reset_state();
        chk("rst_gain_R", 32'(gain_R), 32'd256);
        chk("rst_gain_B", 32'(gain_B), 32'd256);
        chk("rst_stat", 32'(stat_valid), 32'd0);
        chk("rst_outs", 32'({out_vsync, out_hsync, out_den, out_data_R, out_data_G, out_data_B}), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        awb_enable = 1'b1;
        in_vsync = 1'b0; in_hsync = 1'b0; in_den = 1'b0;
        in_data_R = 8'd0; in_data_G = 8'd0; in_data_B = 8'd0;

        rst_v = 1'b1;
        idle(3);
        rst_v = 1'b0;
        idle(1);
        check_reset_state();

        // flat gray: unity gains, pass-through with 2-cycle latency
        frame(100, 100, 100, 100, 2, 4, 1'b1, 256, 256);
        wait_stat(1'b1);
        frame(64, 64, 128, 128, 2, 4, 1'b1, 256, 256);
        wait_stat(1'b1);
        frame(64, 64, 128, 128, 2, 4, 1'b1, 512, 256);
        wait_stat(1'b1);
        // red absent: R divisor 0 -> unity, B gets 128/64
        frame(0, 0, 128, 64, 2, 4, 1'b1, 512, 256);
        wait_stat(1'b1);
        // strong cast: R gain saturates; B output clamps under gain 512
        frame(16, 16, 200, 200, 2, 4, 1'b1, 256, 512);
        wait_stat(1'b1);
        frame(16, 100, 58, 29, 2, 4, 1'b1, 1023, 256);
        wait_stat(1'b1);
        // no valid pixels at all
        frame(50, 50, 50, 50, 2, 4, 1'b0, 256, 512);
        wait_stat(1'b1);

        // short blanking: frame I starts while H is still dividing
        frame(64, 64, 128, 128, 2, 4, 1'b1, 256, 256);
        idle(10);
        frame(64, 64, 192, 128, 8, 8, 1'b1, 256, 256);
        idle(3);
        frame(64, 64, 128, 128, 2, 4, 1'b1, 512, 256);
        wait_stat(1'b0);
        frame(64, 64, 192, 128, 2, 4, 1'b1, 768, 384);
        wait_stat(1'b1);

        // reset in the middle of the B division
        frame(64, 64, 128, 128, 2, 4, 1'b1, 768, 384);
        idle(50);
        rst_v = 1'b1;
        idle(2);
        rst_v = 1'b0;
        idle(1);
        check_reset_state();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b0, 1'b0, 0, 0, 0);
            if (sv_seen) n++;
        end
        chk("no_stat_after_reset", 32'(n), 32'd0);

        frame(64, 64, 128, 64, 2, 4, 1'b1, 256, 256);
        wait_stat(1'b1);
        // bypass: status shows pending-derived gains, data is untouched
        en = 1'b0;
        frame(64, 64, 128, 64, 2, 4, 1'b1, 512, 512);
        wait_stat(1'b1);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/awb_gray_world.md
Name: awb_gray_world

Overview:
- Automatic white balance stage directly downstream of the CFA demosaic; consumes its RGB stream and sync signals.
- Gathers per-frame R/G/B sums (gray-world statistics) and computes R and B gains relative to G with a serial divider during vertical blanking.
- Applies the gains to the following frame and forwards the corrected RGB stream to the next ISP stage.

Parameters:
- source_h, 1024, active pixels per line (informational, sizes SUM_W)
- source_v, 1024, active lines per frame
- SUM_W, 28, accumulator width; must be at least 8 + ceil(log2(source_h*source_v))
- GAIN_W, 10, gain width, unsigned Q2.8 (256 = 1.0, max 1023)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- in_vsync  in  1  frame valid, active-high (from CFA)
- in_hsync  in  1  line valid, active-high
- in_den  in  1  pixel data enable
- in_data_R  in  8  red
- in_data_G  in  8  green
- in_data_B  in  8  blue
- awb_enable  in  1  1 = apply computed gains, 0 = force unity gains
- out_vsync  out  1  in_vsync delayed 2 cycles
- out_hsync  out  1  in_hsync delayed 2 cycles
- out_den  out  1  in_den delayed 2 cycles
- out_data_R  out  8  corrected red
- out_data_G  out  8  corrected green
- out_data_B  out  8  corrected blue
- gain_R  out  GAIN_W  active red gain (status)
- gain_B  out  GAIN_W  active blue gain (status)
- stat_valid  out  1  one-cycle pulse when new pending gains are ready

Behaviour:
- Reset (clk edge with reset=1):
  - All outputs 0 except gain_R = gain_B = 256.
  - Pending gains = 256.
  - Accumulators cleared; FSM in ACCUM.
  - Reset mid-division abandons the division.
- Datapath, 2-cycle latency:
  - Stage 1: prod = pix * gain (8x10 -> 18 bits).
  - Stage 2: (prod + 128) >> 8, saturated to 255.
  - Sync signals are delayed 2 cycles in lockstep with the data.
  - Output data is 0 on any cycle where the delayed den is 0.
  - G always uses gain 256, so G passes through unchanged.
  - When awb_enable = 0, the multipliers use 256 for R and B. Statistics and division still run.
- Statistics: while in_vsync & in_den, sumR/sumG/sumB += pixel (SUM_W bits, no wrap inside the legal frame size).
- Frame end (in_vsync 1->0):
  - Snapshot sumR, sumG, sumB into the divider operand registers.
  - Clear the accumulators in the same cycle. A pixel arriving in that cycle cannot be valid, because vsync is low.
- FSM:
  - ACCUM -> DIV_R on frame end.
  - DIV_R: restoring divide (sumG << 8) / sumR, SUM_W+8 iterations at one bit per cycle.
  - DIV_R -> DIV_B on done. DIV_B: (sumG << 8) / sumB, same cycle count.
  - DIV_B -> UPDATE on done.
  - UPDATE: write pending gains, pulse stat_valid for one cycle, then return to ACCUM.
- Gain rules:
  - Quotient > 1023 saturates to 1023.
  - Divisor 0 gives gain 256 (unity).
  - Divider numerator width is SUM_W+8.
- Gain activation:
  - Active gains (used by the datapath and driven on gain_R/gain_B) load from the pending gains only on in_vsync 0->1.
  - Gains never change mid-frame.
- Short blanking:
  - If in_vsync rises while in DIV_R/DIV_B, the division continues and the new frame is accumulated in parallel.
  - The results become active at the next frame start, one frame later.
  - A frame end arriving while not in ACCUM discards that frame's snapshot. The current division is not restarted.
- Total compute time: 2*(SUM_W+8)+1 cycles (73 at defaults) after vsync falls.

Decomposition:
- Shared package isp_pkg holds:
  - GAIN_ONE = 256, GAIN_MAX = 1023, GAIN_W
  - the AWB FSM state encoding {ACCUM, DIV_R, DIV_B, UPDATE}
- One sub-module awb_divider: a serial restoring divider.
  - Ports: clk, reset, start, dividend, divisor, busy, done, quotient.
  - Instantiated once and time-shared for R then B.

Test Plan:
- Flat frame R=G=B=100, awb_enable=1: gains stay 256; output equals input delayed exactly 2 cycles with syncs aligned.
- Frame 1 uniform R=64, G=128, B=128: stat_valid pulses 73 cycles after vsync falls. gain_R becomes 512 and gain_B stays 256 at the next vsync rise. Frame 2 with R=64 outputs R=128.
- Frame R=16, G=200: gain_R saturates to 1023. Next-frame pixel R=16 -> 64; pixel R=100 -> 255 (clamped).
- Frame with R=0 everywhere: gain_R = 256. Frame with den never asserted: both gains 256.
- Blanking of 10 cycles after a frame with R=64, G=128: gains remain 256 during frame 2 and become 512 at the frame 3 vsync rise. Frame 2 statistics are intact.
- Assert reset during DIV_B, then awb_enable=0 with nonunity pending gains: after reset gains = 256 and outputs = 0. With enable low, output equals input.
